// File: rtl/mem_responder.sv
// Wait-state memory responder on a shared tri-state data bus.
// Accepts one read or write per chip-select assertion and acknowledges it with a one-cycle ready pulse.
module mem_responder #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DEPTH_LOG2  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'h0000,
  parameter int                    WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  CS,
  input  logic                  OE,
  input  logic                  WE,
  output logic                  ready,
  output logic                  busy
);

  // state | meaning
  // IDLE  | waiting for a legal hit (exactly one of OE/WE)
  // WAIT  | counting wait states down; CS low aborts
  // ACK   | access complete, ready pulses
  // HOLD  | parked until CS drops so a held request cannot re-trigger
  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic [DEPTH_LOG2-1:0]   off_q;
  logic                    rd_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    ready_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    hit;
  logic                    accept;
  logic                    commit_d;
  logic [DEPTH_LOG2-1:0]   wr_off_d;
  logic [DATA_WIDTH-1:0]   wr_data_d;
  logic                    drive;

  assign hit    = CS && (address[ADDR_WIDTH-1:DEPTH_LOG2] == BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2]);
  assign accept = (state_q == IDLE) && hit && (OE ^ WE);

  // The write lands on the edge that enters ACK; with no wait states that is the accept edge itself.
  always_comb begin
    commit_d  = 1'b0;
    wr_off_d  = off_q;
    wr_data_d = wdata_q;
    if (!reset) begin
      if (accept && WE && (WS == 4'd0)) begin
        commit_d  = 1'b1;
        wr_off_d  = address[DEPTH_LOG2-1:0];
        wr_data_d = data;
      end else if ((state_q == WAIT) && CS && (cnt_q == 4'd1) && !rd_q) begin
        commit_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            off_q   <= address[DEPTH_LOG2-1:0];
            rd_q    <= OE;
            wdata_q <= data;
            busy_q  <= 1'b1;
            if (WS == 4'd0) begin
              state_q <= ACK;
              ready_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WS;
            end
          end
        end
        WAIT: begin
          if (!CS) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
          end else if (cnt_q == 4'd1) begin
            state_q <= ACK;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK: state_q <= HOLD;
        HOLD: begin
          if (!CS) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_d) mem_q[wr_off_d] <= wr_data_d;
  end

  assign drive = ((state_q == ACK) || (state_q == HOLD)) && rd_q && CS && OE;
  assign data  = drive ? mem_q[off_q] : {DATA_WIDTH{1'bz}};
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (two wait-state settings, one offset base window)
// driven by shared stimulus and checked every cycle against a latency-based transaction model.
module tb_mem_responder;

  localparam int         WS_K   [3] = '{2, 0, 3};
  localparam logic [15:0] BASE_K [3] = '{16'h0000, 16'h0000, 16'h0100};

  logic        clk;
  logic        reset;
  logic [15:0] address;
  logic        CS, OE, WE;
  logic [7:0]  tb_dout;
  logic        tb_drv;
  logic [2:0]  ready_v, busy_v;

  tri1 [7:0] data0;
  tri1 [7:0] data1;
  tri1 [7:0] data2;

  // Bench drives the bus only for pure writes, so it never fights a read drive.
  assign tb_drv = WE && !OE;
  assign data0  = tb_drv ? tb_dout : 8'hzz;
  assign data1  = tb_drv ? tb_dout : 8'hzz;
  assign data2  = tb_drv ? tb_dout : 8'hzz;

  mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH_LOG2(8),
                  .BASE_ADDR(16'h0000), .WAIT_STATES(2)) u_dut0 (
    .clk(clk), .reset(reset), .address(address), .data(data0),
    .CS(CS), .OE(OE), .WE(WE), .ready(ready_v[0]), .busy(busy_v[0]));

  mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH_LOG2(8),
                  .BASE_ADDR(16'h0000), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .reset(reset), .address(address), .data(data1),
    .CS(CS), .OE(OE), .WE(WE), .ready(ready_v[1]), .busy(busy_v[1]));

  mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH_LOG2(8),
                  .BASE_ADDR(16'h0100), .WAIT_STATES(3)) u_dut2 (
    .clk(clk), .reset(reset), .address(address), .data(data2),
    .CS(CS), .OE(OE), .WE(WE), .ready(ready_v[2]), .busy(busy_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] bus(input int k);
    case (k)
      0:       return data0;
      1:       return data1;
      default: return data2;
    endcase
  endfunction

  // Transaction model: an accepted access is tracked by its age in cycles. Ready is due at
  // age WS+1; before that CS low aborts; after the ack the access lingers until CS is low.
  bit         m_act [3];
  int         m_age [3];
  bit         m_wr  [3];
  logic [7:0] m_off [3];
  logic [7:0] m_wd  [3];
  logic [7:0] m_mem [3][256];
  bit         m_val [3][256];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int ws;
      ws = WS_K[k];
      if (reset) begin
        m_act[k] = 1'b0;
      end else if (!m_act[k]) begin
        if (CS && (address[15:8] == BASE_K[k][15:8]) && (OE != WE)) begin
          m_act[k] = 1'b1;
          m_age[k] = 1;
          m_wr[k]  = WE;
          m_off[k] = address[7:0];
          m_wd[k]  = tb_dout;
          if (ws == 0 && WE) begin
            m_mem[k][address[7:0]] = tb_dout;
            m_val[k][address[7:0]] = 1'b1;
          end
        end
      end else if (m_age[k] <= ws) begin
        if (!CS) m_act[k] = 1'b0;
        else begin
          m_age[k]++;
          if (m_age[k] == ws + 1 && m_wr[k]) begin
            m_mem[k][m_off[k]] = m_wd[k];
            m_val[k][m_off[k]] = 1'b1;
          end
        end
      end else if (m_age[k] == ws + 1) begin
        m_age[k]++;
      end else if (!CS) begin
        m_act[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        bit exp_rdy, exp_drv;
        exp_rdy = m_act[k] && (m_age[k] == WS_K[k] + 1);
        exp_drv = m_act[k] && (m_age[k] >= WS_K[k] + 1) && !m_wr[k] && CS && OE;
        chk($sformatf("ready%0d", k), int'(ready_v[k]), int'(exp_rdy));
        chk($sformatf("busy%0d", k), int'(busy_v[k]), int'(m_act[k]));
        if (exp_drv) begin
          if (m_val[k][m_off[k]])
            chk($sformatf("rdata%0d", k), int'(bus(k)), int'(m_mem[k][m_off[k]]));
        end else begin
          chk($sformatf("bus_idle%0d", k), int'(bus(k)), tb_drv ? int'(tb_dout) : 32'hFF);
        end
      end
    end
  end

  int         first_r [3];
  int         pulses  [3];
  int         busy_n  [3];
  logic [7:0] d_rdy   [3];
  logic [7:0] d_first [3];

  // Present a request, hold it for h cycles, then release and watch three idle cycles.
  // Cycle i=1 is the cycle right after the accept edge.
  task automatic run_req(input logic [15:0] a, input logic oe, input logic we,
                         input logic [7:0] dv, input int h, input int rst_at);
    for (int k = 0; k < 3; k++) begin
      first_r[k] = 0; pulses[k] = 0; busy_n[k] = 0; d_rdy[k] = 8'h00; d_first[k] = 8'h00;
    end
    address = a; OE = oe; WE = we; CS = 1'b1; tb_dout = dv;
    for (int i = 1; i <= h + 3; i++) begin
      @(negedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (i == 1) d_first[k] = bus(k);
        if (busy_v[k]) busy_n[k]++;
        if (ready_v[k]) begin
          pulses[k]++;
          if (first_r[k] == 0) begin
            first_r[k] = i;
            d_rdy[k]   = bus(k);
          end
        end
      end
      reset = (i == rst_at);
      if (i == rst_at) begin OE = 1'b0; WE = 1'b0; end
      if (i == h) begin CS = 1'b0; OE = 1'b0; WE = 1'b0; end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; CS = 1'b0; OE = 1'b0; WE = 1'b0; address = 16'h0000; tb_dout = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_ready0", int'(ready_v[0]), 0);
    chk("reset_busy0",  int'(busy_v[0]), 0);
    chk("reset_bus0",   int'(data0), 8'hFF);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    run_req(16'h0010, 1'b0, 1'b1, 8'hA5, 5, 0);
    chk("wr_lat0", first_r[0], 3);
    chk("wr_lat1", first_r[1], 1);
    chk("wr_pulse0", pulses[0], 1);
    chk("wr_miss_busy2", busy_n[2], 0);
    chk("model_mem_a5", int'(m_mem[0][8'h10]), 8'hA5);

    run_req(16'h0010, 1'b1, 1'b0, 8'h00, 5, 0);
    chk("rd_lat0", first_r[0], 3);
    chk("rd_data0", int'(d_rdy[0]), 8'hA5);
    chk("rd_data1", int'(d_rdy[1]), 8'hA5);
    chk("rd_miss_ready2", pulses[2], 0);
    chk("rd_miss_bus2", int'(d_first[2]), 8'hFF);
    chk("rd_wait_bus0", int'(d_first[0]), 8'hFF);

    run_req(16'h0003, 1'b1, 1'b0, 8'h00, 4, 0);
    chk("zw_lat1", first_r[1], 1);
    chk("zw_busy1", busy_n[1], 4);

    run_req(16'h0010, 1'b1, 1'b0, 8'h00, 10, 0);
    chk("held_pulse0", pulses[0], 1);
    chk("held_pulse1", pulses[1], 1);
    chk("held_busy0", busy_n[0], 10);

    run_req(16'h0020, 1'b0, 1'b1, 8'h5A, 5, 0);
    run_req(16'h0020, 1'b0, 1'b1, 8'h3C, 1, 0);
    chk("abort_pulse0", pulses[0], 0);
    chk("abort_busy0", busy_n[0], 1);
    chk("abort_busy1", busy_n[1], 2);
    run_req(16'h0020, 1'b1, 1'b0, 8'h00, 4, 0);
    chk("abort_old0", int'(d_rdy[0]), 8'h5A);
    chk("abort_new1", int'(d_rdy[1]), 8'h3C);

    run_req(16'h0020, 1'b0, 1'b1, 8'h77, 6, 1);
    chk("rst_pulse0", pulses[0], 0);
    chk("rst_busy0", busy_n[0], 1);
    run_req(16'h0020, 1'b1, 1'b0, 8'h00, 4, 0);
    chk("rst_nowrite0", int'(d_rdy[0]), 8'h5A);
    chk("rst_commit1", int'(d_rdy[1]), 8'h77);

    run_req(16'h0010, 1'b1, 1'b1, 8'h00, 4, 0);
    chk("ill_busy0", busy_n[0], 0);
    chk("ill_busy1", busy_n[1], 0);
    chk("ill_bus0", int'(d_first[0]), 8'hFF);

    for (int c = 0; c < 3000; c++) begin
      int r;
      @(negedge clk); #1;
      reset = ($urandom_range(63) == 0);
      if ($urandom_range(5) == 0) CS = ~CS;
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(2))
          0:       address = {8'h00, 4'h0, 4'($urandom_range(15))};
          1:       address = {8'h01, 4'h0, 4'($urandom_range(15))};
          default: address = 16'($urandom);
        endcase
      end
      r  = int'($urandom_range(7));
      OE = (r <= 2) || (r == 6);
      WE = (r >= 3 && r <= 5) || (r == 6);
      tb_dout = 8'($urandom);
    end

    reset = 1'b0; CS = 1'b0; OE = 1'b0; WE = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
